// File: rtl/rice_pkg.sv
// Shared types and header layout for the Rice block sequencer.
// Holds field positions, state encoding, config bundle and header checks.
package rice_pkg;

  localparam int HDR_N_LSB   = 27;
  localparam int HDR_J_LSB   = 22;
  localparam int HDR_K_LSB   = 17;
  localparam int HDR_RSV     = 16;
  localparam int HDR_BLK_LSB = 0;
  localparam int FLD_W       = 5;
  localparam int BLK_W       = 16;
  localparam int N_MAX       = 10;

  typedef enum logic [2:0] {
    IDLE,
    CFG,
    RUN,
    STOP,
    ERR
  } state_e;

  typedef struct packed {
    logic [FLD_W-1:0] n;
    logic [FLD_W-1:0] j;
    logic [FLD_W-1:0] k;
    logic [BLK_W-1:0] blocks;
  } cfg_t;

  function automatic cfg_t hdr_cfg(input logic [31:0] w);
    cfg_t c;
    c.n      = w[HDR_N_LSB +: FLD_W];
    c.j      = w[HDR_J_LSB +: FLD_W];
    c.k      = w[HDR_K_LSB +: FLD_W];
    c.blocks = w[HDR_BLK_LSB +: BLK_W];
    return c;
  endfunction

  function automatic logic hdr_ok(input logic [31:0] w,
                                  input logic [FLD_W-1:0] n_max);
    cfg_t c;
    c = hdr_cfg(w);
    return (c.n != '0) && (c.n <= n_max) &&
           (c.j != '0) && (c.k < c.n) &&
           !w[HDR_RSV] && (c.blocks != '0);
  endfunction

endpackage

// File: rtl/rice_watchdog.sv
// Stall watchdog: counts enabled cycles since the last clear.
// Ports: clk/rst_n, clr_i restarts, en_i counts, expired_o at TIMEOUT.
module rice_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;

  // A clear in the same cycle always beats expiry.
  assign expired_o = en_i & ~clr_i &
                     (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !expired_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/rice_block_sequencer.sv
// Packet controller for the Rice decoder: header parse, decoder control,
// payload forwarding, symbol/block/packet counting, stall and header traps.
module rice_block_sequencer
  import rice_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int SYM_W     = N_MAX,
  parameter int BLK_CNT_W = BLK_W,
  parameter int TIMEOUT   = 1024
) (
  input  logic              clk1,
  input  logic              reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [4:0]        dec_n,
  output logic [4:0]        dec_j,
  output logic [4:0]        dec_k,
  output logic              dec_start,
  output logic              dec_stop,
  output logic              dec_first,
  output logic              dec_wren,
  output logic              dec_rden,
  output logic [DATA_W-1:0] dec_data,
  output logic              dec_datavalid,
  input  logic              dec_full,
  input  logic [SYM_W-1:0]  dec_symbol,
  input  logic              dec_sym_valid,
  output logic [SYM_W-1:0]  out_symbol,
  output logic              out_valid,
  output logic              out_blk_end,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_e               state_q;
  cfg_t                 cfg_q;
  logic [4:0]           sym_cnt_q;
  logic [BLK_CNT_W-1:0] blk_cnt_q;
  logic                 start_q, stop_q, first_q;
  logic                 wr_q, done_q, err_q;
  logic [SYM_W-1:0]     sym_q;
  logic                 vld_q, bend_q, last_q;

  logic run, sym_in, blk_end, pkt_end, expired;

  assign run     = (state_q == RUN);
  assign sym_in  = run & dec_sym_valid;
  assign blk_end = (sym_cnt_q == cfg_q.j - 5'd1);
  assign pkt_end = blk_end &
    (blk_cnt_q == BLK_CNT_W'(cfg_q.blocks - 1'b1));

  rice_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk      (clk1),
    .rst_n    (reset),
    .clr_i    ((state_q == CFG) | sym_in),
    .en_i     (run),
    .expired_o(expired)
  );

  // Reset gates the IDLE ready so it reads 0 while reset is held.
  assign in_ready = reset &
    (((state_q == IDLE) & enable) | (run & ~dec_full));
  assign dec_datavalid = run & in_valid & ~dec_full;
  assign dec_data      = run ? in_data : '0;

  assign dec_n       = cfg_q.n;
  assign dec_j       = cfg_q.j;
  assign dec_k       = cfg_q.k;
  assign dec_start   = start_q;
  assign dec_stop    = stop_q;
  assign dec_first   = first_q;
  assign dec_wren    = wr_q;
  assign dec_rden    = wr_q;
  assign out_symbol  = sym_q;
  assign out_valid   = vld_q;
  assign out_blk_end = bend_q;
  assign out_last    = last_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign err         = err_q;

  always_ff @(posedge clk1 or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cfg_q     <= '0;
      sym_cnt_q <= '0;
      blk_cnt_q <= '0;
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
      first_q   <= 1'b0;
      wr_q      <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      sym_q     <= '0;
      vld_q     <= 1'b0;
      bend_q    <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      vld_q   <= 1'b0;
      bend_q  <= 1'b0;
      last_q  <= 1'b0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (enable && in_valid) begin
            if (hdr_ok(in_data[31:0], 5'(SYM_W))) begin
              state_q   <= CFG;
              cfg_q     <= hdr_cfg(in_data[31:0]);
              sym_cnt_q <= '0;
              blk_cnt_q <= '0;
              start_q   <= 1'b1;
              first_q   <= 1'b1;
              wr_q      <= 1'b1;
            end else begin
              state_q <= ERR;
              stop_q  <= 1'b1;
              err_q   <= 1'b1;
            end
          end
        end
        CFG: begin
          if (!enable) begin
            state_q <= STOP;
            stop_q  <= 1'b1;
            first_q <= 1'b0;
            wr_q    <= 1'b0;
          end else begin
            state_q <= RUN;
          end
        end
        RUN: begin
          if (in_valid && !dec_full) first_q <= 1'b0;
          if (sym_in) begin
            sym_q  <= dec_symbol;
            vld_q  <= 1'b1;
            bend_q <= blk_end;
            last_q <= pkt_end;
            if (blk_end) begin
              sym_cnt_q <= '0;
              blk_cnt_q <= blk_cnt_q + 1'b1;
            end else begin
              sym_cnt_q <= sym_cnt_q + 5'd1;
            end
          end
          // Final symbol outranks both abort and timeout.
          if (sym_in && pkt_end) begin
            state_q <= STOP;
            stop_q  <= 1'b1;
            done_q  <= 1'b1;
            first_q <= 1'b0;
            wr_q    <= 1'b0;
          end else if (!enable) begin
            state_q <= STOP;
            stop_q  <= 1'b1;
            first_q <= 1'b0;
            wr_q    <= 1'b0;
            last_q  <= 1'b0;
          end else if (expired) begin
            state_q <= ERR;
            stop_q  <= 1'b1;
            err_q   <= 1'b1;
            first_q <= 1'b0;
            wr_q    <= 1'b0;
          end
        end
        STOP: begin
          state_q   <= IDLE;
          cfg_q     <= '0;
          sym_cnt_q <= '0;
          blk_cnt_q <= '0;
        end
        ERR: begin
          if (!enable) begin
            state_q   <= IDLE;
            err_q     <= 1'b0;
            cfg_q     <= '0;
            sym_cnt_q <= '0;
            blk_cnt_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rice_block_sequencer.sv
// Randomized scoreboard bench for rice_block_sequencer.
// Symbols and payload words are predicted at issue time and popped on output.
module tb_rice_block_sequencer;

  localparam int DATA_W = 32;
  localparam int SYM_W  = 10;

  logic              clk1 = 1'b0;
  logic              reset;
  logic              enable;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        dec_n, dec_j, dec_k;
  logic              dec_start, dec_stop, dec_first;
  logic              dec_wren, dec_rden;
  logic [DATA_W-1:0] dec_data;
  logic              dec_datavalid;
  logic              dec_full;
  logic [SYM_W-1:0]  dec_symbol;
  logic              dec_sym_valid;
  logic [SYM_W-1:0]  out_symbol;
  logic              out_valid, out_blk_end, out_last;
  logic              busy, done, err;

  int checks = 0;
  int errors = 0;

  logic [SYM_W+1:0]  exp_sym[$];
  logic [DATA_W-1:0] exp_words[$];
  logic [SYM_W+1:0]  mon_s;
  logic [DATA_W-1:0] mon_w;

  rice_block_sequencer #(
    .TIMEOUT(16)
  ) dut (
    .clk1         (clk1),
    .reset        (reset),
    .enable       (enable),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .dec_n        (dec_n),
    .dec_j        (dec_j),
    .dec_k        (dec_k),
    .dec_start    (dec_start),
    .dec_stop     (dec_stop),
    .dec_first    (dec_first),
    .dec_wren     (dec_wren),
    .dec_rden     (dec_rden),
    .dec_data     (dec_data),
    .dec_datavalid(dec_datavalid),
    .dec_full     (dec_full),
    .dec_symbol   (dec_symbol),
    .dec_sym_valid(dec_sym_valid),
    .out_symbol   (out_symbol),
    .out_valid    (out_valid),
    .out_blk_end  (out_blk_end),
    .out_last     (out_last),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clk1 = ~clk1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk1) begin
    if (out_valid) begin
      if (exp_sym.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sym_extra got %0h want none", out_symbol);
      end else begin
        mon_s = exp_sym.pop_front();
        chk("sym", {out_symbol, out_blk_end, out_last}, mon_s);
      end
    end
    if (dec_datavalid) begin
      if (exp_words.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL word_extra got %0h want none", dec_data);
      end else begin
        mon_w = exp_words.pop_front();
        chk("word", dec_data, mon_w);
      end
    end
  end

  function automatic logic [31:0] mk(input int n, input int j,
                                     input int k, input int b);
    return {n[4:0], j[4:0], k[4:0], 1'b0, b[15:0]};
  endfunction

  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  task automatic send_hdr(input logic [31:0] h);
    in_data       = h;
    in_valid      = 1'b1;
    dec_sym_valid = 1'b0;
    dec_full      = 1'b0;
    @(negedge clk1);
    chk("hdr_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic cfg_check(input logic [31:0] h);
    @(negedge clk1);
    chk("cfg_start", dec_start, 1);
    chk("cfg_first", dec_first, 1);
    chk("cfg_wr", {dec_wren, dec_rden, in_ready}, 3'b110);
    chk("cfg_njk", {dec_n, dec_j, dec_k}, h[31:17]);
    step();
  endtask

  task automatic run_packet(input logic [31:0] h, input bit burst,
                            input int pct, input bit use_pl,
                            input int abort_after);
    int j, total, issued, cyc, gap;
    bit first_pend, full, vld, sym;
    logic [31:0] word;
    j      = int'(h[26:22]);
    total  = j * int'(h[15:0]);
    issued = 0;
    cyc    = 0;
    gap    = 0;
    first_pend = 1'b1;
    word   = $urandom;
    send_hdr(h);
    cfg_check(h);
    while (issued < total) begin
      if (abort_after >= 0 && issued == abort_after) begin
        enable        = 1'b0;
        in_valid      = 1'b0;
        dec_sym_valid = 1'b0;
        dec_full      = 1'b0;
        @(negedge clk1);
        chk("abort_pre", {busy, dec_stop}, 2'b10);
        step();
        @(negedge clk1);
        chk("abort_stop", {dec_stop, done, out_last, busy}, 4'b1001);
        step();
        @(negedge clk1);
        chk("abort_idle", {busy, dec_stop, done}, 3'b000);
        enable = 1'b1;
        step();
        return;
      end
      full = burst ? (cyc >= 5 && cyc < 10) : ($urandom % 4 == 0);
      vld  = use_pl ? ((burst && full) || ($urandom % 4 != 0)) : 1'b0;
      sym  = ($urandom % 100 < pct) || (gap >= 8);
      dec_full      = full;
      in_valid      = vld;
      in_data       = vld ? word : $urandom;
      dec_sym_valid = sym;
      dec_symbol    = SYM_W'($urandom);
      if (sym) begin
        issued++;
        gap = 0;
        exp_sym.push_back({dec_symbol, (issued % j) == 0,
                           issued == total});
      end else begin
        gap++;
      end
      if (vld && !full) exp_words.push_back(word);
      @(negedge clk1);
      chk("run_ready", in_ready, !full);
      chk("run_dv", dec_datavalid, vld && !full);
      chk("run_first", dec_first, first_pend);
      chk("run_ctl", {dec_start, dec_stop, dec_wren, dec_rden, err},
          5'b00110);
      if (vld && !full) begin
        first_pend = 1'b0;
        word = $urandom;
      end
      step();
      cyc++;
    end
    dec_sym_valid = 1'b0;
    dec_full      = 1'b0;
    in_valid      = 1'b1;
    in_data       = $urandom;
    @(negedge clk1);
    chk("stop_flags", {dec_stop, done, busy, in_ready, dec_datavalid},
        5'b11100);
    step();
    in_valid = 1'b0;
    @(negedge clk1);
    chk("idle_flags", {dec_stop, done, busy, err}, 4'b0000);
    step();
    chk("sb_drain", exp_sym.size() + exp_words.size(), 0);
  endtask

  task automatic bad_hdr(input logic [31:0] h);
    send_hdr(h);
    in_valid = 1'b1;
    @(negedge clk1);
    chk("err_entry", {err, dec_stop, dec_start, in_ready, busy,
                      dec_datavalid}, 6'b110010);
    step();
    @(negedge clk1);
    chk("err_hold", {err, dec_stop, in_ready}, 3'b100);
    enable = 1'b0;
    step();
    in_valid = 1'b0;
    @(negedge clk1);
    chk("err_clear", {busy, err}, 2'b00);
    enable = 1'b1;
    step();
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_ctl"}, {in_ready, dec_n, dec_j, dec_k, dec_start,
        dec_stop, dec_first, dec_wren, dec_rden, dec_datavalid,
        out_valid, out_blk_end, out_last, busy, done, err}, 0);
    chk({nm, "_dat"}, {dec_data, out_symbol}, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout got hang want finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] h;
    int n, jj, kk, bb;
    reset         = 1'b0;
    enable        = 1'b1;
    in_valid      = 1'b0;
    in_data       = 32'hDEAD_BEEF;
    dec_full      = 1'b0;
    dec_symbol    = '0;
    dec_sym_valid = 1'b0;
    #3;
    chk_zero("reset");
    step();
    step();
    reset = 1'b1;

    run_packet(32'h4282_0002, 1'b0, 60, 1'b1, -1);
    bad_hdr(32'h6282_0002);
    bad_hdr(mk(0, 3, 0, 1));
    bad_hdr(mk(4, 0, 1, 1));
    bad_hdr(mk(4, 3, 4, 1));
    bad_hdr(mk(4, 3, 1, 1) | 32'h0001_0000);
    bad_hdr(mk(4, 3, 1, 0));
    bad_hdr(mk(11, 3, 1, 1));

    run_packet(mk(6, 5, 2, 4), 1'b1, 30, 1'b1, -1);

    h = mk(8, 6, 3, 3);
    send_hdr(h);
    cfg_check(h);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk1);
      chk("wd_run", {err, busy, dec_stop}, 3'b010);
      step();
    end
    in_valid = 1'b1;
    @(negedge clk1);
    chk("wd_err", {err, dec_stop, done, in_ready, dec_datavalid},
        5'b11000);
    step();
    @(negedge clk1);
    chk("wd_hold", {err, dec_stop, done}, 3'b100);
    enable = 1'b0;
    step();
    in_valid = 1'b0;
    @(negedge clk1);
    chk("wd_clear", {busy, err}, 2'b00);
    enable = 1'b1;
    step();

    run_packet(mk(8, 6, 3, 3), 1'b0, 50, 1'b1, 10);
    run_packet(mk(5, 3, 1, 2), 1'b0, 50, 1'b1, -1);

    h = mk(5, 4, 2, 2);
    send_hdr(h);
    cfg_check(h);
    step();
    step();
    #2;
    reset = 1'b0;
    #1;
    chk_zero("rst_async");
    exp_sym.delete();
    exp_words.delete();
    step();
    reset = 1'b1;
    @(negedge clk1);
    chk("rst_idle", {busy, in_ready}, 2'b01);
    step();
    run_packet(mk(7, 4, 6, 2), 1'b0, 70, 1'b1, -1);

    run_packet(mk(10, 3, 9, 2), 1'b0, 50, 1'b1, -1);
    for (int r = 0; r < 4; r++) begin
      n  = 1 + int'($urandom % 10);
      jj = 1 + int'($urandom % 8);
      kk = int'($urandom % n);
      bb = 1 + int'($urandom % 3);
      run_packet(mk(n, jj, kk, bb), 1'b0, 40 + 10 * r, 1'b1, -1);
    end

    run_packet(mk(3, 1, 0, 65535), 1'b0, 100, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
